// File: rtl/instruction_prefetch.sv
// Instruction prefetch buffer: streams sequential fetches into a DEPTH-entry FIFO,
// keeping buffered + in-flight words within capacity and dropping stale responses after a redirect.
module instruction_prefetch #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_pc_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [CNT_W:0] occupancy;
  logic           accept;
  logic           rsp;
  logic           drop;
  logic           push;
  logic           pop;

  // stale responses still in flight occupy capacity until they are dropped
  assign occupancy     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign mem_req_o     = rst_n && !write_pc_i && (occupancy < (CNT_W+1)'(DEPTH));
  assign mem_addr_o    = fetch_pc_q;
  assign accept        = mem_req_o && mem_gnt_i;
  assign rsp           = mem_rvalid_i && (outstanding_q != '0);
  assign drop          = rsp && (discard_q != '0);
  assign push          = rsp && !drop && !write_pc_i;
  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = instr_mem[rd_ptr_q];
  assign pc_o          = pc_mem[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);

    if (write_pc_i) begin
      fetch_pc_d = pc_i;
      resp_pc_d  = pc_i;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      discard_d  = outstanding_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      if (drop)   discard_d  = discard_q - CNT_W'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + ADDR_W'(4);
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // payload storage carries no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= resp_pc_q;
      instr_mem[wr_ptr_q] <= mem_rdata_i;
    end
  end

endmodule
